// File: rtl/instr_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_loader_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Number of stream bytes needed to fill one instruction word.
  function automatic int calc_bytes_per_instr(input int instr_width);
    return (instr_width + BYTE_WIDTH - 1) / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/instr_word_assembler.sv
// Collects little-endian bytes into one instruction word; bits beyond INSTR_WIDTH are dropped.
// Latency: word_full_o is combinational with the final byte's take; word_o is updated at that edge.
// Backpressure: none of its own; the parent only asserts take_i on real handshake transfers.
module instr_word_assembler
  import instr_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   take_i,
  input  logic [7:0]             byte_i,
  output logic                   word_full_o,
  output logic [INSTR_WIDTH-1:0] word_o
);

  localparam int BYTES_PER_INSTR = calc_bytes_per_instr(INSTR_WIDTH);
  localparam int CW              = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
  localparam int WW              = BYTES_PER_INSTR * BYTE_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_INSTR - 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] word_q, word_d;
  logic [CW+2:0]          shamt;

  // Bit offset of the slot the next byte lands in.
  assign shamt       = {cnt_q, 3'b000};
  assign word_full_o = take_i && (cnt_q == LAST);
  assign word_o      = word_q;

  // Next-state: insert the byte into its slot and advance/wrap the byte counter.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (take_i) begin
      word_d = (word_q & ~INSTR_WIDTH'(WW'(8'hFF) << shamt))
             | INSTR_WIDTH'(WW'(byte_i) << shamt);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a byte stream into instruction memory at addresses 0..num_instr-1; busy until finished.
// Latency: one WRITE cycle after the last byte of each word; BYTES_PER_INSTR+1 cycles per word minimum.
// Backpressure: byte_ready only in RECV (and CKSUM when INSTR_LOADER_CHECKSUM_EN is defined).
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int INSTR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    num_instr,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  // DEPTH = 2**ADDR_WIDTH, expressed at count width so DEPTH itself is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0] num_q, num_d;
  logic                bad_q, bad_d;
  logic                legal;
  logic                start_ok;
  logic                take;
  logic                word_full;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]          cks_q, cks_d;
  logic                cks_err_q, cks_err_d;
`endif

  assign legal    = (num_instr != '0) && (num_instr <= DEPTH);
  assign start_ok = (state_q == IDLE) && start && legal;
  assign take     = byte_valid && byte_ready;

`ifdef INSTR_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == RECV) || (state_q == CKSUM);
  assign error      = bad_q || ((state_q == DONE) && cks_err_q);
`else
  assign byte_ready = (state_q == RECV);
  assign error      = bad_q;
`endif
  assign wr_en   = (state_q == WRITE);
  assign wr_addr = idx_q[ADDR_WIDTH-1:0];
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) || bad_q;

  instr_word_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (start_ok),
    .take_i      (take && (state_q == RECV)),
    .byte_i      (byte_in),
    .word_full_o (word_full),
    .word_o      (wr_data)
  );

  // FSM next-state, index/count bookkeeping and illegal-count pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    bad_d   = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
    cks_d     = cks_q;
    cks_err_d = cks_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            num_d   = num_instr;
            idx_d   = '0;
            state_d = RECV;
`ifdef INSTR_LOADER_CHECKSUM_EN
            cks_d     = '0;
            cks_err_d = 1'b0;
`endif
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      RECV: begin
        if (take) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          cks_d = cks_q ^ byte_in;
`endif
          if (word_full) state_d = WRITE;
        end
      end
      WRITE: begin
        if ((idx_q + 1'b1) == num_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = CKSUM;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RECV;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CKSUM: begin
        if (take) begin
          cks_err_d = (byte_in != cks_q);
          state_d   = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any load in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      bad_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_q     <= '0;
      cks_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      bad_q   <= bad_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      cks_q     <= cks_d;
      cks_err_q <= cks_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader against a byte-list reference model.
// Latency: n/a.
// Backpressure: producer holds byte_in/byte_valid until byte_ready, with optional random gaps.
module tb_instr_loader;

  localparam int AW    = 12;
  localparam int IW    = 9;
  localparam int BPI   = 2;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   num_instr;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [IW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          error;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  wr_t        got_q[$];
  logic [7:0] bytes_q[$];
  int         done_total = 0;
  int         rdy_bad    = 0;
  int         checks     = 0;
  int         errors     = 0;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_instr  (num_instr),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Record every memory write and done pulse; flag byte_ready during a write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got_q.push_back('{a: wr_addr, d: wr_data});
      if (byte_ready !== 1'b0) rdy_bad++;
    end
    if (done === 1'b1) done_total++;
  end

  // Reference: instruction idx is its bytes taken little-endian, truncated to IW bits.
  function automatic logic [IW-1:0] model_word(input int idx);
    longint w = 0;
    for (int k = 0; k < BPI; k++) w += longint'(bytes_q[idx*BPI + k]) << (8*k);
    return IW'(w % (longint'(1) << IW));
  endfunction

  task automatic do_start(input int n);
    start     = 1'b1;
    num_instr = (AW+1)'(n);
    @(negedge clk);
    start     = 1'b0;
    num_instr = (AW+1)'($urandom);
  endtask

  // Called just after a negedge; returns just after the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit last_of_word);
    int g;
    int n;
    g = gaps ? $urandom_range(0, 3) : 0;
    repeat (g) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready=%b after %0d cycles, required 1", byte_ready, n);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    checks++;
    if (wr_en !== last_of_word) begin
      errors++;
      $display("FAIL write_latency: wr_en=%b one cycle after byte %02h, required %b", wr_en, b, last_of_word);
    end
  endtask

  task automatic wait_done(output bit seen);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    seen = (done === 1'b1);
  endtask

  // One complete load of n instructions from bytes_q, checked against the model.
  task automatic run_load(input int n, input bit gaps, input int inject);
    int         bw;
    int         bd;
    int         br;
    bit         seen;
    logic [7:0] x;
    bw = got_q.size();
    bd = done_total;
    br = rdy_bad;
    x  = 8'h00;
    do_start(n);
    for (int i = 0; i < n*BPI; i++) begin
      if (i == inject) begin
        start     = 1'b1;
        num_instr = (AW+1)'(5);
        @(negedge clk);
        start     = 1'b0;
      end
      send_byte(bytes_q[i], gaps, (i % BPI) == BPI-1);
      x ^= bytes_q[i];
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(x, gaps, 1'b0);
`endif
    wait_done(seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done=%b, required 1 (n=%0d)", done, n);
    end
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL done_flags: error=%b busy=%b at done, required error=0 busy=1", error, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: busy=%b done=%b, required 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() - bw != n) begin
      errors++;
      $display("FAIL write_count: %0d writes, required %0d", got_q.size() - bw, n);
    end
    for (int i = 0; i < n && bw + i < got_q.size(); i++) begin
      checks++;
      if (got_q[bw+i].a !== AW'(i) || got_q[bw+i].d !== model_word(i)) begin
        errors++;
        $display("FAIL write_%0d: addr=%h data=%h, required addr=%h data=%h",
                 i, got_q[bw+i].a, got_q[bw+i].d, AW'(i), model_word(i));
      end
    end
    checks++;
    if (done_total - bd != 1) begin
      errors++;
      $display("FAIL done_count: %0d done pulses, required 1", done_total - bd);
    end
    checks++;
    if (rdy_bad != br) begin
      errors++;
      $display("FAIL ready_in_write: byte_ready high in %0d write cycles, required 0", rdy_bad - br);
    end
  endtask

  task automatic fill_bytes(input int n);
    bytes_q.delete();
    for (int i = 0; i < n*BPI; i++) bytes_q.push_back(8'($urandom));
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    start      = 1'b0;
    num_instr  = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wr_en=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
               byte_ready, wr_en, busy, done, error, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int bw;
    logic [IW-1:0] exp_w [3];
    exp_w[0] = 9'h12A;
    exp_w[1] = 9'h0FF;
    exp_w[2] = 9'h134;
    bytes_q = '{8'h2A, 8'h01, 8'hFF, 8'h00, 8'h34, 8'h01};
    bw = got_q.size();
    run_load(3, 1'b0, -1);
    for (int i = 0; i < 3 && bw + i < got_q.size(); i++) begin
      checks++;
      if (got_q[bw+i].d !== exp_w[i]) begin
        errors++;
        $display("FAIL basic_word_%0d: data=%h, required %h", i, got_q[bw+i].d, exp_w[i]);
      end
    end
  endtask

  task automatic test_gaps;
    bytes_q = '{8'h2A, 8'h01, 8'hFF, 8'h00, 8'h34, 8'h01};
    run_load(3, 1'b1, -1);
    repeat (6) begin
      int n;
      n = $urandom_range(1, 8);
      fill_bytes(n);
      run_load(n, 1'b1, -1);
    end
  endtask

  task automatic check_illegal(input int n);
    int bw;
    int bd;
    bw = got_q.size();
    bd = done_total;
    do_start(n);
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_%0d_pulse: done=%b error=%b busy=%b, required 1 1 0", n, done, error, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_%0d_once: done=%b error=%b, required 0 0", n, done, error);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() != bw || done_total - bd != 1) begin
      errors++;
      $display("FAIL illegal_%0d_effects: writes=%0d dones=%0d, required 0 1", n, got_q.size() - bw, done_total - bd);
    end
  endtask

  task automatic test_bounds;
    check_illegal(0);
    check_illegal(DEPTH + 1);
    fill_bytes(DEPTH);
    run_load(DEPTH, 1'b0, -1);
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].a !== 12'hFFF) begin
      errors++;
      $display("FAIL full_depth_last_addr: addr=%h, required fff",
               got_q.size() == 0 ? 12'h000 : got_q[got_q.size()-1].a);
    end
  endtask

  task automatic test_reset_mid;
    int bw;
    fill_bytes(2);
    bw = got_q.size();
    do_start(2);
    for (int i = 0; i < 3; i++) send_byte(bytes_q[i], 1'b0, (i % BPI) == BPI-1);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({byte_ready, wr_en, busy, done, error} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdy=%b wr_en=%b busy=%b done=%b err=%b addr=%h data=%h, required all 0",
               byte_ready, wr_en, busy, done, error, wr_addr, wr_data);
    end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() - bw != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_abort: writes=%0d busy=%b, required 1 0", got_q.size() - bw, busy);
    end
    fill_bytes(2);
    run_load(2, 1'b1, -1);
  endtask

  task automatic test_start_busy;
    fill_bytes(2);
    run_load(2, 1'b1, 1);
    fill_bytes(2);
    run_load(2, 1'b0, 2);
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic cks_case(input logic [7:0] b, input logic exp_err);
    bit seen;
    do_start(1);
    send_byte(8'h2A, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(b, 1'b0, 1'b0);
    wait_done(seen);
    checks++;
    if (!seen || error !== exp_err) begin
      errors++;
      $display("FAIL checksum_%02h: done=%b error=%b, required 1 %b", b, done, error, exp_err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_checksum;
    cks_case(8'h2B, 1'b0);
    cks_case(8'h00, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_bounds();
    test_reset_mid();
    test_start_busy();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Program-memory writer: the loading end of the instruction-memory interface, and counterpart of the instruction ROM read path.
- Accepts a byte stream (from a UART/debug link) over a valid/ready handshake and assembles it into INSTR_WIDTH-bit words.
- Writes those words to consecutive instruction-memory addresses starting at 0.
- Holds the fetch side off (busy) until the requested number of instructions is loaded.

Parameters:
- ADDR_WIDTH, 12: instruction address width; memory depth DEPTH = 2**ADDR_WIDTH.
- INSTR_WIDTH, 9: instruction word width.
- Derived localparam BYTES_PER_INSTR = ceil(INSTR_WIDTH/8); equals 2 at the defaults.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  load request; sampled only in IDLE.
- num_instr  in  ADDR_WIDTH+1  number of instructions to load; legal range 1..DEPTH.
- byte_in  in  8  stream data.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader can accept a byte.
- wr_en  out  1  instruction-memory write strobe.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  INSTR_WIDTH  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a load terminates.
- error  out  1  one-cycle pulse, coincident with done, on a failed load.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; byte_ready, wr_en, busy, done, error=0; wr_addr=0; wr_data=0; byte and instruction counters cleared.
- Reset during a load aborts it at that edge. No write is issued afterwards.
- Handshake: a byte transfers only on an edge where byte_valid && byte_ready. byte_ready is high only in RECV. The producer holds byte_in stable until the transfer.
- IDLE:
  - start=1 with num_instr in 1..DEPTH: latch num_instr, clear counters, go to RECV.
  - start=1 with num_instr=0 or num_instr>DEPTH: stay in IDLE; pulse done=1 and error=1 on the next cycle; no write.
- RECV:
  - Bytes arrive little-endian: byte k fills word bits [8k+7:8k].
  - Bits above INSTR_WIDTH-1 in the last byte are discarded.
  - After byte BYTES_PER_INSTR-1 transfers, go to WRITE.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_addr = current instruction index, wr_data = assembled word; byte_ready=0.
  - Next edge: if index+1 == latched count, go to DONE; otherwise increment the index and return to RECV.
- DONE (1 cycle): done=1; error per the optional feature; then IDLE.
- start is ignored while busy=1.
- wr_addr wrap: never wraps. The count is limited to DEPTH, so the last address is DEPTH-1. When num_instr=DEPTH the index counter needs ADDR_WIDTH+1 bits.
- Throughput: BYTES_PER_INSTR+1 cycles per instruction minimum. Latency from the last byte transfer to wr_en is 1 cycle.
- byte_valid gaps in RECV stall indefinitely; there is no timeout.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, enter a CKSUM state with byte_ready=1.
  - Accept exactly one byte and compare it to the XOR of all data bytes received in this load.
  - Then go to DONE; error=1 with done on mismatch, error=0 on match.
- Undefined:
  - No CKSUM state; WRITE goes directly to DONE.
  - error is raised only for an illegal num_instr.

Decomposition:
- Package instr_loader_pkg contains:
  - state enum (IDLE, RECV, WRITE, CKSUM, DONE);
  - BYTE_WIDTH=8;
  - a function computing BYTES_PER_INSTR from INSTR_WIDTH.
- Natural sub-module instr_word_assembler: byte counter plus word shift/insert register. Outputs word_full and word. Cleared by the parent on start and reset.
- The parent owns the FSM, address/count counters and the checksum accumulator.

Test Plan:
- Basic load: start, num_instr=3, bytes 2A 01 FF 00 34 01 (no stalls) -> writes 9'h12A@0, 9'h0FF@1, 9'h134@2; one done pulse; error=0; busy falls with done.
- Backpressure and gaps: random byte_valid gaps, same 3 instructions -> identical writes; byte_ready=0 during every WRITE cycle; no byte lost or duplicated.
- Bounds: num_instr=0 -> done+error pulse, no wr_en. num_instr=4097 at defaults -> same. num_instr=4096 -> last write at addr 12'hFFF, no wrap.
- Reset mid-load: rst_n=0 after the first byte of instruction 1 -> all outputs 0 next cycle, no further wr_en. A new start then writes from address 0.
- start while busy: pulse start with num_instr=5 during a 2-instruction load -> ignored; exactly 2 writes and one done.
- Checksum, with INSTR_LOADER_CHECKSUM_EN: bytes 2A 01 then checksum 2B -> error=0. Checksum 00 -> error=1 with done.
